// File: rtl/adler32_pkg.sv
// Shared types and constants for the adler32 job scheduler.
package adler32_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        WAIT,
        DONE
    } state_t;

    // Checksum of an empty message; returned directly for zero-length jobs.
    localparam logic [31:0] ADLER_EMPTY = 32'h0000_0001;
    localparam int          ADLER_MOD   = 65521;
    localparam int          SIZE_W      = 32;
    localparam int          DATA_W      = 8;

endpackage

// File: rtl/adler32_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping past NREQ-1 back to 0. The pointer register lives in the caller.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  id,
    output logic            any
);

    int idx;

    // Scan offsets from farthest to nearest so the nearest asserted request wins.
    always_comb begin
        grant = '0;
        id    = '0;
        any   = 1'b0;
        idx   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                id         = IDW'(idx);
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adler32_sched.sv
// Round-robin scheduler sharing one adler32 engine among NREQ requesters.
// One job in flight: arbitrate, load size, stream bytes, wait for checksum,
// report the tagged result (or a timeout) with a one-cycle done pulse.
module adler32_sched
    import adler32_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*SIZE_W-1:0]   req_size,
    input  logic [NREQ*DATA_W-1:0]   src_data,
    output logic [NREQ-1:0]          gnt,
    output logic                     busy,
    output logic                     done,
    output logic [IDW-1:0]           done_id,
    output logic [31:0]              result,
    output logic                     err,
    output logic                     eng_size_valid,
    output logic [SIZE_W-1:0]        eng_size,
    output logic                     eng_data_start,
    output logic [DATA_W-1:0]        eng_data,
    input  logic                     eng_checksum_valid,
    input  logic [31:0]              eng_checksum
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    state_t              state_reg, state_next;
    logic [IDW-1:0]      ptr_reg;
    logic [IDW-1:0]      id_reg;
    logic [SIZE_W-1:0]   size_reg;
    logic [SIZE_W-1:0]   cnt_reg;
    logic [TMR_W-1:0]    tmr_reg;
    logic [31:0]         result_reg;
    logic                err_reg;

    logic [NREQ-1:0]     arb_grant;
    logic [IDW-1:0]      arb_id;
    logic                arb_any;
    logic [SIZE_W-1:0]   size_terms [NREQ];
    logic [SIZE_W-1:0]   win_size;
    logic                timeout_hit;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_reg),
        .grant (arb_grant),
        .id    (arb_id),
        .any   (arb_any)
    );

    // One-hot grant selects the winner's size; the grant pulse follows the latched id.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign size_terms[gi] = arb_grant[gi] ? req_size[gi*SIZE_W +: SIZE_W] : '0;
            assign gnt[gi]        = (state_reg == LOAD) && (id_reg == IDW'(gi));
        end
    endgenerate

    // OR-reduce the masked sizes into the winner's size.
    always_comb begin
        win_size = '0;
        for (int k = 0; k < NREQ; k++) begin
            win_size = win_size | size_terms[k];
        end
    end

    assign timeout_hit = (tmr_reg == TMR_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and engine/client-facing outputs.
    always_comb begin
        state_next     = state_reg;
        busy           = (state_reg != IDLE);
        done           = 1'b0;
        done_id        = '0;
        result         = '0;
        err            = 1'b0;
        eng_size_valid = 1'b0;
        eng_size       = '0;
        eng_data_start = 1'b0;
        eng_data       = '0;
        case (state_reg)
            IDLE: begin
                if (arb_any) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                eng_size_valid = 1'b1;
                eng_size       = size_reg;
                state_next     = (size_reg == '0) ? DONE : STREAM;
            end
            STREAM: begin
                eng_data       = src_data[id_reg*DATA_W +: DATA_W];
                // cnt still equals size only on the first streamed byte
                eng_data_start = (cnt_reg == size_reg);
                if (cnt_reg == SIZE_W'(1)) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (eng_checksum_valid || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                done_id    = id_reg;
                result     = result_reg;
                err        = err_reg;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Job bookkeeping: winner latch, rr pointer, byte counter, wait timer, result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_reg    <= '0;
            id_reg     <= '0;
            size_reg   <= '0;
            cnt_reg    <= '0;
            tmr_reg    <= '0;
            result_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (arb_any) begin
                        id_reg   <= arb_id;
                        size_reg <= win_size;
                        ptr_reg  <= (arb_id == IDW'(NREQ - 1)) ? '0 : arb_id + 1'b1;
                    end
                end
                LOAD: begin
                    cnt_reg <= size_reg;
                    if (size_reg == '0) begin
                        result_reg <= ADLER_EMPTY;
                        err_reg    <= 1'b0;
                    end
                end
                STREAM: begin
                    cnt_reg <= cnt_reg - 1'b1;
                    tmr_reg <= '0;
                end
                WAIT: begin
                    // A checksum arriving on the timeout cycle still counts.
                    if (eng_checksum_valid) begin
                        result_reg <= eng_checksum;
                        err_reg    <= 1'b0;
                    end else if (timeout_hit) begin
                        result_reg <= '0;
                        err_reg    <= 1'b1;
                    end else begin
                        tmr_reg <= tmr_reg + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adler32_sched.sv
// Self-checking bench for adler32_sched with a behavioural adler32 engine,
// byte-streaming requester models and a closed-form checksum reference.
module tb_adler32_sched;
    import adler32_pkg::*;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 16;
    localparam int MAXJ    = 4;
    localparam int MAXB    = 128;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req;
    logic [NREQ*32-1:0]  req_size;
    logic [NREQ*8-1:0]   src_data;
    logic [NREQ-1:0]     gnt;
    logic                busy;
    logic                done;
    logic [IDW-1:0]      done_id;
    logic [31:0]         result;
    logic                err;
    logic                eng_size_valid;
    logic [31:0]         eng_size;
    logic                eng_data_start;
    logic [7:0]          eng_data;
    logic                eng_checksum_valid;
    logic [31:0]         eng_checksum;

    adler32_sched #(
        .NREQ    (NREQ),
        .IDW     (IDW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req                (req),
        .req_size           (req_size),
        .src_data           (src_data),
        .gnt                (gnt),
        .busy               (busy),
        .done               (done),
        .done_id            (done_id),
        .result             (result),
        .err                (err),
        .eng_size_valid     (eng_size_valid),
        .eng_size           (eng_size),
        .eng_data_start     (eng_data_start),
        .eng_data           (eng_data),
        .eng_checksum_valid (eng_checksum_valid),
        .eng_checksum       (eng_checksum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    // ---------------- engine model ----------------
    bit   eng_mute = 1'b0;
    int   e_rem, e_a, e_b, e_an, e_bn;
    assign e_an = (e_a + int'(eng_data)) % ADLER_MOD;
    assign e_bn = (e_b + e_an) % ADLER_MOD;

    always @(posedge clk) begin
        if (!rst_n) begin
            e_rem              <= 0;
            e_a                <= 1;
            e_b                <= 0;
            eng_checksum_valid <= 1'b0;
            eng_checksum       <= '0;
        end else begin
            eng_checksum_valid <= 1'b0;
            if (eng_size_valid) begin
                e_rem <= int'(eng_size);
                e_a   <= 1;
                e_b   <= 0;
            end else if (e_rem != 0) begin
                e_a   <= e_an;
                e_b   <= e_bn;
                e_rem <= e_rem - 1;
                if (e_rem == 1 && !eng_mute) begin
                    eng_checksum_valid <= 1'b1;
                    eng_checksum       <= {e_bn[15:0], e_an[15:0]};
                end
            end
        end
    end

    // ---------------- requester models ----------------
    logic [7:0] job_data [NREQ][MAXJ][MAXB];
    int         job_len  [NREQ][MAXJ];
    int         job_cnt  [NREQ];
    int         job_idx  [NREQ];
    bit         armed    [NREQ];
    int         pos      [NREQ];
    int         sj       [NREQ];
    logic [7:0] cur_byte [NREQ];

    typedef struct {
        int          cyc;
        int          id;
        logic [31:0] res;
        logic        err;
    } ev_t;

    ev_t done_q[$];
    ev_t exp_q[$];
    ev_t gnt_q[$];
    ev_t start_q[$];

    // Closed form: A = 1 + sum d_k, B = N + sum (N-k)*d_k, both mod 65521.
    function automatic logic [31:0] ref_adler(int i, int j);
        longint a = 1;
        longint b = 0;
        longint n = longint'(job_len[i][j]);
        for (int k = 0; k < job_len[i][j]; k++) begin
            a += longint'(job_data[i][j][k]);
            b += (n - longint'(k)) * longint'(job_data[i][j][k]);
        end
        b += n;
        a = a % ADLER_MOD;
        b = b % ADLER_MOD;
        return {b[15:0], a[15:0]};
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < NREQ; i++) begin
            req[i] = (job_idx[i] < job_cnt[i]);
            if (req[i]) req_size[32*i +: 32] = 32'(job_len[i][job_idx[i]]);
            else        req_size[32*i +: 32] = $urandom;
            src_data[8*i +: 8] = cur_byte[i];
        end
    endtask

    task automatic add_job_str(int i, string s);
        int j = job_cnt[i];
        job_len[i][j] = s.len();
        for (int k = 0; k < s.len(); k++) job_data[i][j][k] = s[k];
        job_cnt[i]++;
    endtask

    task automatic add_job_rand(int i, int len);
        int j = job_cnt[i];
        job_len[i][j] = len;
        for (int k = 0; k < len; k++) job_data[i][j][k] = 8'($urandom);
        job_cnt[i]++;
    endtask

    task automatic clear_jobs();
        for (int i = 0; i < NREQ; i++) begin
            job_cnt[i] = 0;
            job_idx[i] = 0;
            armed[i]   = 1'b0;
        end
        drive_inputs();
    endtask

    task automatic clear_logs();
        done_q.delete();
        exp_q.delete();
        gnt_q.delete();
        start_q.delete();
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n    = 1'b0;
        eng_mute = 1'b0;
        clear_jobs();
        repeat (2) @(negedge clk);
        clear_logs();
        rst_n = 1'b1;
    endtask

    task automatic wait_dones(int n, int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (done_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Requesters: advance byte streams, consume grants, record expectations.
    initial begin : driver
        ev_t e;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (armed[i]) begin
                    cur_byte[i] = job_data[i][sj[i]][pos[i]];
                    pos[i]++;
                    if (pos[i] == job_len[i][sj[i]]) armed[i] = 1'b0;
                end else begin
                    cur_byte[i] = 8'($urandom);
                end
                if (rst_n && gnt[i] && job_idx[i] < job_cnt[i]) begin
                    e.cyc = cyc;
                    e.id  = i;
                    if (job_len[i][job_idx[i]] != 0 && eng_mute) begin
                        e.res = 32'h0;
                        e.err = 1'b1;
                    end else begin
                        e.res = ref_adler(i, job_idx[i]);
                        e.err = 1'b0;
                    end
                    exp_q.push_back(e);
                    sj[i]    = job_idx[i];
                    pos[i]   = 0;
                    armed[i] = (job_len[i][job_idx[i]] > 0);
                    job_idx[i]++;
                end
            end
            drive_inputs();
        end
    end

    // Output monitor: log grant pulses, data-start strobes and completions.
    initial begin : monitor
        int gid;
        forever begin
            @(negedge clk);
            if (gnt != '0) begin
                gid = -1;
                for (int i = NREQ - 1; i >= 0; i--) if (gnt[i]) gid = i;
                gnt_q.push_back('{cyc, gid, 32'(gnt), 1'b0});
            end
            if (eng_data_start) start_q.push_back('{cyc, 0, 32'(eng_data), 1'b0});
            if (done) done_q.push_back('{cyc, int'(done_id), result, err});
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        add_job_rand(0, 4);
        add_job_rand(2, 4);
        drive_inputs();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({gnt, busy, done, done_id, result, err, eng_size_valid, eng_size,
             eng_data_start, eng_data} !== '0) begin
            $display("FAIL reset_outputs: got gnt=%b busy=%b done=%b res=%h err=%b esv=%b es=%h eds=%b ed=%h want all zero",
                     gnt, busy, done, result, err, eng_size_valid, eng_size, eng_data_start, eng_data);
        end else passed++;
        clear_jobs();
        @(negedge clk);
        clear_logs();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || gnt !== '0) begin
            $display("FAIL reset_idle: got busy=%b gnt=%b want 0/0", busy, gnt);
        end else passed++;
        $display("test_reset: done");
    endtask

    task automatic test_single();
        bit ok;
        int t0;
        @(negedge clk);
        #1;
        clear_logs();
        add_job_str(0, "abc");
        drive_inputs();
        t0 = cyc;
        wait_dones(1, 60, ok);
        checks++;
        if (!ok) $display("FAIL t1_timeout: got %0d dones want 1", done_q.size());
        else passed++;
        checks++;
        if (gnt_q.size() !== 1) $display("FAIL t1_gnt_count: got %0d want 1", gnt_q.size());
        else passed++;
        if (gnt_q.size() > 0) begin
            checks++;
            if (gnt_q[0].id !== 0 || gnt_q[0].cyc !== t0 + 1)
                $display("FAIL t1_gnt: got id=%0d cyc=%0d want id=0 cyc=%0d", gnt_q[0].id, gnt_q[0].cyc, t0 + 1);
            else passed++;
        end
        checks++;
        if (start_q.size() !== 1) $display("FAIL t1_start_count: got %0d want 1", start_q.size());
        else passed++;
        if (start_q.size() > 0) begin
            checks++;
            if (start_q[0].res !== 32'h61 || start_q[0].cyc !== t0 + 2)
                $display("FAIL t1_start: got byte=%h cyc=%0d want 61 cyc=%0d", start_q[0].res, start_q[0].cyc, t0 + 2);
            else passed++;
        end
        if (ok) begin
            checks++;
            if (done_q[0].id !== 0 || done_q[0].res !== 32'h024D_0127 || done_q[0].err !== 1'b0)
                $display("FAIL t1_done: got id=%0d res=%h err=%b want 0 024d0127 0", done_q[0].id, done_q[0].res, done_q[0].err);
            else passed++;
            checks++;
            if (done_q[0].cyc !== t0 + 6)
                $display("FAIL t1_latency: got cyc=%0d want %0d", done_q[0].cyc, t0 + 6);
            else passed++;
        end
        $display("test_single: id=0 size=3 done");
    endtask

    task automatic test_two_same_cycle();
        bit ok;
        reset_dut();
        @(negedge clk);
        #1;
        add_job_str(1, "Wikipedia");
        add_job_rand(2, 1);
        job_data[2][0][0] = 8'h00;
        drive_inputs();
        wait_dones(2, 100, ok);
        checks++;
        if (!ok) $display("FAIL t2_timeout: got %0d dones want 2", done_q.size());
        else passed++;
        if (ok) begin
            checks++;
            if (done_q[0].id !== 1 || done_q[0].res !== 32'h11E6_0398 || done_q[0].err !== 1'b0)
                $display("FAIL t2_first: got id=%0d res=%h err=%b want 1 11e60398 0", done_q[0].id, done_q[0].res, done_q[0].err);
            else passed++;
            checks++;
            if (done_q[1].id !== 2 || done_q[1].res !== 32'h0001_0001 || done_q[1].err !== 1'b0)
                $display("FAIL t2_second: got id=%0d res=%h err=%b want 2 00010001 0", done_q[1].id, done_q[1].res, done_q[1].err);
            else passed++;
        end
        $display("test_two_same_cycle: ids 1,2 done");
    endtask

    task automatic test_fairness();
        bit ok;
        int per_id [NREQ];
        reset_dut();
        @(negedge clk);
        #1;
        for (int j = 0; j < 3; j++)
            for (int i = 0; i < NREQ; i++) add_job_rand(i, $urandom_range(1, 8));
        drive_inputs();
        wait_dones(12, 600, ok);
        checks++;
        if (!ok) $display("FAIL t3_timeout: got %0d dones want 12", done_q.size());
        else passed++;
        for (int i = 0; i < NREQ; i++) per_id[i] = 0;
        if (ok) begin
            for (int k = 0; k < 12; k++) begin
                per_id[done_q[k].id]++;
                checks++;
                if (done_q[k].id !== k % NREQ || gnt_q[k].id !== k % NREQ)
                    $display("FAIL t3_order_%0d: got done_id=%0d gnt_id=%0d want %0d", k, done_q[k].id, gnt_q[k].id, k % NREQ);
                else passed++;
                checks++;
                if (done_q[k].res !== exp_q[k].res || done_q[k].err !== 1'b0)
                    $display("FAIL t3_result_%0d: got res=%h err=%b want %h 0", k, done_q[k].res, done_q[k].err, exp_q[k].res);
                else passed++;
                $display("test_fairness: job %0d id=%0d res=%h", k, done_q[k].id, done_q[k].res);
            end
            for (int i = 0; i < NREQ; i++) begin
                checks++;
                if (per_id[i] !== 3) $display("FAIL t3_served_%0d: got %0d want 3", i, per_id[i]);
                else passed++;
            end
        end
    endtask

    task automatic test_zero_size();
        bit ok;
        int t0;
        @(negedge clk);
        #1;
        clear_logs();
        add_job_rand(3, 0);
        drive_inputs();
        t0 = cyc;
        wait_dones(1, 30, ok);
        checks++;
        if (!ok) $display("FAIL t4_timeout: got %0d dones want 1", done_q.size());
        else passed++;
        checks++;
        if (gnt_q.size() !== 1 || start_q.size() !== 0)
            $display("FAIL t4_pulses: got gnts=%0d starts=%0d want 1 0", gnt_q.size(), start_q.size());
        else passed++;
        if (ok && gnt_q.size() > 0) begin
            checks++;
            if (gnt_q[0].id !== 3 || gnt_q[0].cyc !== t0 + 1)
                $display("FAIL t4_gnt: got id=%0d cyc=%0d want 3 %0d", gnt_q[0].id, gnt_q[0].cyc, t0 + 1);
            else passed++;
            checks++;
            if (done_q[0].cyc !== t0 + 2 || done_q[0].id !== 3 || done_q[0].res !== ADLER_EMPTY || done_q[0].err !== 1'b0)
                $display("FAIL t4_done: got cyc=%0d id=%0d res=%h err=%b want %0d 3 00000001 0",
                         done_q[0].cyc, done_q[0].id, done_q[0].res, done_q[0].err, t0 + 2);
            else passed++;
        end
        $display("test_zero_size: id=3 done");
    endtask

    task automatic test_timeout();
        bit ok;
        int t0;
        int n;
        @(negedge clk);
        #1;
        clear_logs();
        eng_mute = 1'b1;
        n = 2;
        add_job_rand(0, n);
        drive_inputs();
        t0 = cyc;
        wait_dones(1, 80, ok);
        checks++;
        if (!ok) $display("FAIL t5_timeout: got %0d dones want 1", done_q.size());
        else passed++;
        if (ok) begin
            checks++;
            if (done_q[0].err !== 1'b1 || done_q[0].res !== 32'h0 || done_q[0].id !== 0)
                $display("FAIL t5_err: got id=%0d res=%h err=%b want 0 00000000 1", done_q[0].id, done_q[0].res, done_q[0].err);
            else passed++;
            checks++;
            if (done_q[0].cyc !== t0 + 2 + n + TIMEOUT)
                $display("FAIL t5_when: got cyc=%0d want %0d", done_q[0].cyc, t0 + 2 + n + TIMEOUT);
            else passed++;
        end
        $display("test_timeout: err job done");
        eng_mute = 1'b0;
        @(negedge clk);
        #1;
        clear_logs();
        n = 5;
        add_job_rand(2, n);
        drive_inputs();
        t0 = cyc;
        wait_dones(1, 80, ok);
        checks++;
        if (!ok) $display("FAIL t5_next_timeout: got %0d dones want 1", done_q.size());
        else passed++;
        if (ok) begin
            checks++;
            if (done_q[0].id !== 2 || done_q[0].res !== exp_q[0].res || done_q[0].err !== 1'b0 || done_q[0].cyc !== t0 + 3 + n)
                $display("FAIL t5_next: got id=%0d res=%h err=%b cyc=%0d want 2 %h 0 %0d",
                         done_q[0].id, done_q[0].res, done_q[0].err, done_q[0].cyc, exp_q[0].res, t0 + 3 + n);
            else passed++;
        end
        $display("test_timeout: follow-up job done");
    endtask

    task automatic test_reset_mid_job();
        bit ok;
        int t0;
        reset_dut();
        @(negedge clk);
        #1;
        add_job_rand(0, 100);
        drive_inputs();
        t0 = cyc;
        repeat (52) @(negedge clk);
        checks++;
        if (busy !== 1'b1) $display("FAIL t6_midstream: got busy=%b want 1", busy);
        else passed++;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({gnt, busy, done, done_id, result, err, eng_size_valid, eng_size,
             eng_data_start, eng_data} !== '0)
            $display("FAIL t6_reset_outputs: got busy=%b done=%b esv=%b eds=%b ed=%h want all zero",
                     busy, done, eng_size_valid, eng_data_start, eng_data);
        else passed++;
        clear_jobs();
        @(negedge clk);
        clear_logs();
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (done_q.size() !== 0) $display("FAIL t6_no_done: got %0d dones want 0", done_q.size());
        else passed++;
        t0 = cyc;
        add_job_str(0, "abc");
        drive_inputs();
        wait_dones(1, 60, ok);
        checks++;
        if (!ok) $display("FAIL t6_timeout: got %0d dones want 1", done_q.size());
        else passed++;
        if (ok) begin
            checks++;
            if (done_q[0].res !== 32'h024D_0127 || done_q[0].err !== 1'b0 || done_q[0].cyc !== t0 + 6)
                $display("FAIL t6_rerun: got res=%h err=%b cyc=%0d want 024d0127 0 %0d",
                         done_q[0].res, done_q[0].err, done_q[0].cyc, t0 + 6);
            else passed++;
        end
        $display("test_reset_mid_job: rerun done");
    endtask

    initial begin : main
        for (int i = 0; i < NREQ; i++) cur_byte[i] = 8'h00;
        clear_jobs();
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_two_same_cycle();
        test_fairness();
        test_zero_size();
        test_timeout();
        test_reset_mid_job();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
